// File: rtl/svc_rv_ex_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// A normal divide takes XLEN CALC cycles followed by a one-cycle done pulse.
// Divide-by-zero and signed overflow skip CALC and go straight to DONE.
module svc_rv_ex_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] div_abs;
  logic [CW-1:0]   cnt;
  logic            is_rem;
  logic            is_signed;
  logic            sign_a;
  logic            sign_b;

  // Operand preparation for the IDLE accept cycle.
  // op[0] clear means signed, op[1] set means the remainder is wanted.
  logic            in_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] fast_res;

  assign in_signed = ~op[0];
  assign a_neg     = in_signed & dividend[XLEN-1];
  assign b_neg     = in_signed & divisor[XLEN-1];
  assign a_abs     = a_neg ? -dividend : dividend;
  assign b_abs     = b_neg ? -divisor  : divisor;
  assign div_zero  = (divisor == '0);
  assign ovf       = in_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);

  // x/0 gives all-ones with remainder x; MIN/-1 gives MIN with remainder 0.
  // The overflow quotient equals the dividend itself.
  assign fast_res  = div_zero ? (op[1] ? dividend : '1)
                              : (op[1] ? '0 : dividend);

  // One restoring step: shift {rem,quo} left, subtract if it fits.
  // One extra bit on rem keeps the shifted value from overflowing the compare.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  assign rem_sh = {rem, quo[XLEN-1]};
  assign diff   = rem_sh - {1'b0, div_abs};
  assign ge     = ~diff[XLEN];
  assign rem_nx = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx = {quo[XLEN-2:0], ge};

  // Signed fixup: quotient negative iff signs differ, remainder follows dividend.
  assign q_fix  = (is_signed && (sign_a ^ sign_b)) ? -quo_nx : quo_nx;
  assign r_fix  = (is_signed && sign_a) ? -rem_nx : rem_nx;

  // Hold the front of the pipeline while a divide is outstanding.
  assign stall  = start & ~done & ~flush;

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      quo       <= '0;
      rem       <= '0;
      div_abs   <= '0;
      cnt       <= '0;
      is_rem    <= 1'b0;
      is_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              is_rem    <= op[1];
              is_signed <= in_signed;
              sign_a    <= a_neg;
              sign_b    <= b_neg;
              if (div_zero || ovf) begin
                result <= fast_res;
                done   <= 1'b1;
                state  <= DONE;
              end else begin
                quo     <= a_abs;
                rem     <= '0;
                div_abs <= b_abs;
                cnt     <= CW'(XLEN-1);
                busy    <= 1'b1;
                state   <= CALC;
              end
            end
          end
          CALC: begin
            quo <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              result <= is_rem ? r_fix : q_fix;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_svc_rv_ex_div.sv
// Directed bench for svc_rv_ex_div: latency, results, fast path, flush, reset.
module tb_svc_rv_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  svc_rv_ex_div #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Move to the next cycle; inputs are driven 1 time unit after the edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Present an op in the current cycle (cycle 0), hold start, and follow it
  // to done. Checks stall/busy each cycle, the done cycle and the result.
  // Returns one cycle after done with start still asserted.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] exp_res);
    int c;
    op = o; dividend = a; divisor = b; start = 1'b1;
    c = 0;
    forever begin
      #1;
      chk({tag, "_stall"}, {31'd0, stall}, {31'd0, (c != lat)});
      chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (lat > 1 && c >= 1 && c < lat)});
      if (done) break;
      if (c >= 60) begin
        chk({tag, "_timeout"}, 32'(c), 32'(lat));
        break;
      end
      nxt();
      c++;
    end
    chk({tag, "_lat"}, 32'(c), 32'(lat));
    chk({tag, "_res"}, result, exp_res);
    nxt();
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; flush = 1'b0; start = 1'b0; op = 2'b00;
    dividend = '0; divisor = '0;
    nxt(); nxt();
    #1;
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_stall",  {31'd0, stall}, 32'd0);
    rst = 1'b0;
    nxt();

    // Normal path, back-to-back with start held throughout.
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 33, 32'd14);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 33, 32'd2);
    run_op("div_m7_2",   DIV,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
    run_op("rem_m7_2",   REM,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
    run_op("rem_7_m2",   REM,  32'd7, 32'hFFFF_FFFE, 33, 32'd1);
    run_op("div_7_m2",   DIV,  32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
    run_op("divu_big",   DIVU, 32'hFFFF_FFFF, 32'd16, 33, 32'h0FFF_FFFF);

    // Fast path: divide by zero and signed overflow.
    run_op("divu_5_0",   DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run_op("rem_5_0",    REM,  32'd5, 32'd0, 1, 32'd5);
    run_op("div_5_0",    DIV,  32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run_op("rem_m7_0",   REM,  32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9);
    run_op("div_ovf",    DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("rem_ovf",    REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

    // Result holds after done with start dropped; operands change freely.
    start = 1'b0; dividend = 32'd77; divisor = 32'd0;
    nxt(); nxt();
    #1;
    chk("hold_res",  result, 32'd0);
    chk("hold_done", {31'd0, done}, 32'd0);
    nxt();

    // Flush in flight at cycle 10, new op accepted at cycle 12.
    held = result;
    op = DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("fl_nodone_pre", {31'd0, done}, 32'd0);
      nxt();
    end
    flush = 1'b1;
    #1;
    chk("fl_stall10", {31'd0, stall}, 32'd0);
    chk("fl_done10",  {31'd0, done}, 32'd0);
    nxt();
    flush = 1'b0; start = 1'b0;
    #1;
    chk("fl_busy11",  {31'd0, busy}, 32'd0);
    chk("fl_done11",  {31'd0, done}, 32'd0);
    chk("fl_res11",   result, held);
    nxt();
    run_op("fl_divu_9_3", DIVU, 32'd9, 32'd3, 33, 32'd3);
    start = 1'b0;
    nxt();

    // Flush in IDLE with start: op must not be accepted.
    op = DIVU; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
    nxt();
    flush = 1'b0; start = 1'b0;
    #1;
    chk("fl_idle_busy", {31'd0, busy}, 32'd0);
    chk("fl_idle_done", {31'd0, done}, 32'd0);
    nxt();

    // Back-to-back, then a synchronous reset mid third op.
    run_op("bb_divu_20_4", DIVU, 32'd20, 32'd4, 33, 32'd5);
    run_op("bb_remu_20_6", REMU, 32'd20, 32'd6, 33, 32'd2);
    op = DIVU; dividend = 32'd100; divisor = 32'd7;
    for (int i = 0; i < 5; i++) nxt();
    #1;
    chk("rs_busy5", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    nxt();
    #1;
    chk("rs_done6", {31'd0, done}, 32'd0);
    chk("rs_busy6", {31'd0, busy}, 32'd0);
    chk("rs_res6",  result, 32'd0);
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      nxt();
      #1;
      chk("rs_nodone", {31'd0, done}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
